bcd_xs3_seq_ctrl: RTL and testbench

//   Sequencer for a packed multi-digit BCD word. It converts one word to excess-3 (XS-3) by reusing one

---
 rtl/bcd_xs3_pkg.sv | 15 +
 rtl/bcd_to_xs3.sv | 11 +
 rtl/bcd_xs3_seq_ctrl.sv | 109 ++++++++++
 tb/tb_bcd_xs3_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the BCD to excess-3 word sequencer.
package bcd_xs3_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } seq_state_t;

  localparam bcd_digit_t XS3_OFFSET = 4'd3;
  localparam bcd_digit_t BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_to_xs3.sv
// Single-digit combinational BCD to excess-3 converter; result wraps mod 16.
module bcd_to_xs3
  import bcd_xs3_pkg::*;
(
  input  bcd_digit_t bcd,
  output bcd_digit_t xs3
);

  assign xs3 = bcd + XS3_OFFSET;

endmodule

// File: rtl/bcd_xs3_seq_ctrl.sv
// Converts a packed NDIG-digit BCD word to excess-3, one digit per cycle, LSD first.
// Optional sticky non-BCD digit flag enabled by defining BCD_CHECK_EN.
module bcd_xs3_seq_ctrl
  import bcd_xs3_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*NDIG-1:0] in_bcd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*NDIG-1:0] out_xs3,
  output logic            busy,
  output logic            err
);

  localparam int unsigned W  = 4 * NDIG;
  localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CntLast = CW'(NDIG - 1);

  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [W-1:0]  out_q, out_d;
  bcd_digit_t    digit_xs3;

  bcd_to_xs3 u_conv (
    .bcd (shreg_q[3:0]),
    .xs3 (digit_xs3)
  );

`ifdef BCD_CHECK_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    out_d   = out_q;
`ifdef BCD_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_bcd;
          cnt_d   = '0;
`ifdef BCD_CHECK_EN
          err_d   = 1'b0;
`endif
          state_d = CONV;
        end
      end
      CONV: begin
        out_d[{cnt_q, 2'b00} +: 4] = digit_xs3;
        shreg_d = shreg_q >> 4;
        cnt_d   = cnt_q + 1'b1;
`ifdef BCD_CHECK_EN
        if (shreg_q[3:0] > BCD_MAX) err_d = 1'b1;
`endif
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      out_q   <= '0;
`ifdef BCD_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
`ifdef BCD_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // in_ready depends on state only, never on in_valid
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_xs3   = out_q;

`ifdef BCD_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Scoreboard bench for bcd_xs3_seq_ctrl (NDIG=4), plus directed NDIG=1 and NDIG=16 instances.
module tb_bcd_xs3_seq_ctrl;

  localparam int NDIG = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_bcd = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_xs3;
  logic        busy;
  logic        err;

  logic        v1 = 1'b0, r1, ov1, busy1, err1;
  logic [3:0]  b1 = '0, x1;
  logic        v16 = 1'b0, r16, ov16, busy16, err16;
  logic [63:0] b16 = '0, x16;

  int n_checks = 0;
  int n_fail   = 0;
  int or_mode  = 0;  // 0: ready high, 1: random, 2: held low

  always #5 clk = ~clk;

  bcd_xs3_seq_ctrl #(.NDIG(NDIG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
    .out_valid(out_valid), .out_ready(out_ready), .out_xs3(out_xs3), .busy(busy), .err(err)
  );

  bcd_xs3_seq_ctrl #(.NDIG(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_bcd(b1),
    .out_valid(ov1), .out_ready(1'b1), .out_xs3(x1), .busy(busy1), .err(err1)
  );

  bcd_xs3_seq_ctrl #(.NDIG(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .in_bcd(b16),
    .out_valid(ov16), .out_ready(1'b1), .out_xs3(x16), .busy(busy16), .err(err16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: each nibble independently plus three, wrapped to 4 bits; bit 16 = non-BCD seen
  function automatic logic [16:0] model(input logic [15:0] w);
    int word = 0;
    int bad  = 0;
    for (int i = 0; i < NDIG; i++) begin
      int d = (int'(w) / (16 ** i)) % 16;
      word += ((d + 3) % 16) * (16 ** i);
      if (d > 9) bad = 1;
    end
`ifndef BCD_CHECK_EN
    bad = 0;
`endif
    return {bad[0], word[15:0]};
  endfunction

  // Scoreboard monitor
  logic [16:0] exp_q[$];
  bit          pending = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          rst_chk = 0;
  bit          hold_v = 0;
  logic [15:0] held_xs3;
  logic        held_err;

  always @(negedge clk) begin
    bit exp_rdy;
    logic [16:0] e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      pending = 0;
      hold_v  = 0;
      rst_chk = 1;
    end else begin
      if (rst_chk) begin
        chk("reset_out_xs3", 64'(out_xs3), 64'h0);
        chk("reset_err", 64'(err), 64'h0);
        rst_chk = 0;
      end
      exp_rdy = !pending;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(pending));
      chk("out_valid", 64'(out_valid), 64'(pending && (cyc - acc_cyc >= NDIG + 1)));
      if (out_valid) begin
        if (hold_v) begin
          chk("hold_out_xs3", 64'(out_xs3), 64'(held_xs3));
          chk("hold_err", 64'(err), 64'(held_err));
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 64'(out_xs3), 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            chk("out_xs3", 64'(out_xs3), 64'(e[15:0]));
            chk("err", 64'(err), 64'(e[16]));
          end
          pending = 0;
          hold_v  = 0;
        end else begin
          hold_v   = 1;
          held_xs3 = out_xs3;
          held_err = err;
        end
      end
      if (in_valid && exp_rdy) begin
        pending = 1;
        acc_cyc = cyc;
        exp_q.push_back(model(in_bcd));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom % 2);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [15:0] w);
    bit ok = 0;
    in_bcd   = w;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) chk("send_timeout", 64'(w), 64'hFFFF_FFFF);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    if (!ok) chk("valid_timeout", 64'(out_valid), 64'h1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (!pending && exp_q.size() == 0) ok = 1;
    end
    if (!ok) chk("drain_timeout", 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    int n;
    logic [15:0] w;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic conversion and back-to-back words
    send(16'h0395);
    drain();
    send(16'h0000);
    send(16'h9999);
    drain();

    // Backpressure in DONE
    @(posedge clk); #1 or_mode = 2;
    send(16'h1234);
    wait_valid();
    repeat (6) @(negedge clk);
    @(posedge clk); #1 or_mode = 0;
    drain();

    // Reset during the second CONV cycle discards the word
    send(16'h5678);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send(16'h0001);
    drain();

    // Non-BCD digit, then a clean word clears err
    send(16'h00A0);
    send(16'h0000);
    drain();

    // Random words under random backpressure
    or_mode = 1;
    for (int k = 0; k < 40; k++) begin
      w = 16'($urandom);
      send(w);
      repeat ($urandom % 3) @(posedge clk);
      #1;
    end
    @(posedge clk); #1 or_mode = 0;
    drain();

    // NDIG=1: valid two edges after accept
    @(posedge clk); #1 b1 = 4'h7; v1 = 1'b1;
    n = 0;
    for (int i = 0; i < 50 && !r1; i++) @(negedge clk);
    @(posedge clk); #1 v1 = 1'b0;
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ov1) break;
      @(posedge clk);
      n++;
    end
    chk("ndig1_latency", 64'(n), 64'd2);
    chk("ndig1_out_valid", 64'(ov1), 64'h1);
    chk("ndig1_out_xs3", 64'(x1), 64'hA);

    // NDIG=16: all nines, valid seventeen edges after accept
    @(posedge clk); #1 b16 = 64'h9999_9999_9999_9999; v16 = 1'b1;
    for (int i = 0; i < 50 && !r16; i++) @(negedge clk);
    @(posedge clk); #1 v16 = 1'b0;
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ov16) break;
      @(posedge clk);
      n++;
    end
    chk("ndig16_latency", 64'(n), 64'd17);
    chk("ndig16_out_valid", 64'(ov16), 64'h1);
    chk("ndig16_out_xs3", x16, 64'hCCCC_CCCC_CCCC_CCCC);
    chk("ndig16_err", 64'(err16), 64'h0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
